// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, constants and bit-period helper
package uart_pkg;

  localparam int DATA_BITS   = 8;
  localparam int DEF_CLKFREQ = 12000000;
  localparam int DEF_BAUD    = 115200;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BRK    = 3'd5
  } state_e;

  // Clocks per bit; integer division, so baud error is the caller's concern.
  function automatic int calc_cpb(input int clkfreq, input int baud);
    return clkfreq / baud;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - two-flop synchroniser for an asynchronous input pin
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_q1;
  logic r_q2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q1 <= RST_VAL;
      r_q2 <= RST_VAL;
    end else begin
      r_q1 <= i_d;
      r_q2 <= r_q1;
    end
  end

  assign o_q = r_q2;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with framing error and break hold-off
// Optional parity bit and parity_err when UART_RX_PARITY_EN is defined.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKFREQ = DEF_CLKFREQ,
  parameter int BAUD    = DEF_BAUD
`ifdef UART_RX_PARITY_EN
  ,
  parameter logic PARITY_ODD = 1'b0
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int CPB  = calc_cpb(CLKFREQ, BAUD);
  localparam int HALF = CPB / 2;
  localparam int TW   = $clog2(CPB);
  localparam int IW   = $clog2(DATA_BITS);

  localparam logic [TW-1:0] HALF_LAST = TW'(HALF - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CPB - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_START  = START;
  localparam logic [2:0] S_DATA   = DATA;
  localparam logic [2:0] S_PARITY = PARITY;
  localparam logic [2:0] S_STOP   = STOP;
  localparam logic [2:0] S_BRK    = BRK;

`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_AFTER_DATA = S_PARITY;
`else
  localparam logic [2:0] S_AFTER_DATA = S_STOP;
`endif

  logic                 w_rx_s;
  logic                 w_half;
  logic                 w_bit_end;
  logic [2:0]           r_state;
  logic [TW-1:0]        r_timer;
  logic [IW-1:0]        r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [7:0]           r_data;
  logic                 r_valid;
  logic                 r_frame_err;

  uart_sync #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .i_d  (rx),
    .o_q  (w_rx_s)
  );

  assign w_half    = (r_timer == HALF_LAST);
  assign w_bit_end = (r_timer == BIT_LAST);

`ifdef UART_RX_PARITY_EN
  logic r_par_bit;
  logic r_parity_err;
  logic w_par_bad;

  assign w_par_bad  = ((^r_shift) ^ PARITY_ODD) != r_par_bit;
  assign parity_err = r_parity_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par_bit    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= 1'b0;
      if (w_bit_end && r_state == S_PARITY) begin
        r_par_bit <= w_rx_s;
      end
      // Reported on the stop-bit decision cycle, alongside any frame_err.
      if (w_bit_end && r_state == S_STOP) begin
        r_parity_err <= w_par_bad;
      end
    end
  end
`else
  logic w_par_bad;

  assign w_par_bad  = 1'b0;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_timer <= '0;
          if (!w_rx_s) begin
            r_state <= S_START;
          end
        end
        S_START: begin
          // Mid-start-bit check rejects glitches shorter than half a bit.
          if (w_half) begin
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_state   <= w_rx_s ? S_IDLE : S_DATA;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_timer   <= '0;
            r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            r_bit_idx <= r_bit_idx + 1'b1;
            if (r_bit_idx == IDX_LAST) begin
              r_state <= S_AFTER_DATA;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_timer <= '0;
            r_state <= S_STOP;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (w_bit_end) begin
            r_timer <= '0;
            if (w_rx_s) begin
              if (!w_par_bad) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
              end
              r_state <= S_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_BRK;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_BRK: begin
          // Hold off until the line releases so a break is not seen as starts.
          if (w_rx_s) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx (scoreboard of expected bytes)
// Exercises the parity path as well when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

  localparam int CLKFREQ = 12000000;
  localparam int BAUD    = 115200;
  localparam int CPB     = CLKFREQ / BAUD;
  localparam int HALF    = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int SAMPLE_BITS = 10;
`else
  localparam int SAMPLE_BITS = 9;
`endif
  localparam int LATENCY = 2 + HALF + SAMPLE_BITS * CPB + 1;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_ferr = 0;
  int n_perr = 0;
  int n_overlap = 0;
  int rd_ptr = 0;
  logic [7:0] last_good = 8'h00;

  logic [7:0] exp_q[$];
  logic [7:0] obs_data[$];
  int         obs_cyc[$];

  uart_rx #(
    .CLKFREQ(CLKFREQ),
    .BAUD   (BAUD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      obs_data.push_back(data);
      obs_cyc.push_back(cyc);
      n_valid++;
    end
    if (frame_err) n_ferr++;
    if (parity_err) n_perr++;
    if (valid && (frame_err || parity_err)) n_overlap++;
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_ok);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ ~par_ok);
`endif
    drive_bit(stop);
  endtask

  task automatic test_reset();
    int v0, f0;
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b want 0", parity_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    v0 = n_valid; f0 = n_ferr;
    repeat (2000) @(posedge clk);
    #1;
    checks++; if (n_valid - v0 != 0) begin errors++; $display("FAIL idle_valid: got %0d pulses want 0", n_valid - v0); end
    checks++; if (n_ferr - f0 != 0) begin errors++; $display("FAIL idle_ferr: got %0d pulses want 0", n_ferr - f0); end
  endtask

  task automatic test_single_byte();
    int v0, f0, st;
    logic [7:0] e;
    v0 = n_valid; f0 = n_ferr;
    exp_q.push_back(8'hA5);
    st = cyc;
    send_frame(8'hA5, 1'b1, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    checks++; if (n_valid - v0 != 1) begin errors++; $display("FAIL single_count: got %0d want 1", n_valid - v0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd_ptr >= obs_data.size()) begin errors++; $display("FAIL single_data: got none want %h", e); end
      else begin
        if (obs_data[rd_ptr] !== e) begin errors++; $display("FAIL single_data: got %h want %h", obs_data[rd_ptr], e); end
        checks++;
        if (obs_cyc[rd_ptr] - st != LATENCY) begin errors++; $display("FAIL single_latency: got %0d want %0d", obs_cyc[rd_ptr] - st, LATENCY); end
        rd_ptr++;
      end
    end
    last_good = 8'hA5;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b want 0", busy); end
    checks++; if (n_ferr - f0 != 0) begin errors++; $display("FAIL single_ferr: got %0d want 0", n_ferr - f0); end
  endtask

  task automatic test_glitch();
    int v0, f0;
    v0 = n_valid; f0 = n_ferr;
    rx = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_hi: got %b want 1", busy); end
    rx = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_lo: got %b want 0", busy); end
    checks++; if (n_valid - v0 != 0) begin errors++; $display("FAIL glitch_valid: got %0d want 0", n_valid - v0); end
    checks++; if (n_ferr - f0 != 0) begin errors++; $display("FAIL glitch_ferr: got %0d want 0", n_ferr - f0); end
  endtask

  task automatic test_framing_break();
    int v0, f0;
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h3C, 1'b0, 1'b1);
    repeat (3000) @(posedge clk);
    #1;
    checks++; if (n_ferr - f0 != 1) begin errors++; $display("FAIL break_ferr: got %0d want 1", n_ferr - f0); end
    checks++; if (n_valid - v0 != 0) begin errors++; $display("FAIL break_valid: got %0d want 0", n_valid - v0); end
    checks++; if (data !== last_good) begin errors++; $display("FAIL break_data: got %h want %h", data, last_good); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL break_busy_hi: got %b want 1", busy); end
    rx = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_busy_lo: got %b want 0", busy); end
    checks++; if (n_ferr - f0 != 1) begin errors++; $display("FAIL break_retrigger: got %0d want 1", n_ferr - f0); end
  endtask

  task automatic test_back_to_back();
    int v0;
    logic [7:0] pat [3];
    logic [7:0] e;
    pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'h55;
    v0 = n_valid;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(pat[i]);
      send_frame(pat[i], 1'b1, 1'b1);
    end
    repeat (20) @(posedge clk);
    #1;
    checks++; if (n_valid - v0 != 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", n_valid - v0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd_ptr >= obs_data.size()) begin errors++; $display("FAIL b2b_data: got none want %h", e); end
      else begin
        if (obs_data[rd_ptr] !== e) begin errors++; $display("FAIL b2b_data: got %h want %h", obs_data[rd_ptr], e); end
        rd_ptr++;
      end
    end
    last_good = 8'h55;
  endtask

  task automatic test_mid_reset();
    int v0, f0;
    logic [7:0] b;
    logic [7:0] e;
    b = 8'h81;
    v0 = n_valid; f0 = n_ferr;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    rx = b[4];
    repeat (CPB / 2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    rx = 1'b1;
    rst_n = 1'b1;
    repeat (1500) @(posedge clk);
    #1;
    checks++; if (n_valid - v0 != 0) begin errors++; $display("FAIL midrst_valid: got %0d want 0", n_valid - v0); end
    checks++; if (n_ferr - f0 != 0) begin errors++; $display("FAIL midrst_ferr: got %0d want 0", n_ferr - f0); end
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h want 00", data); end
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b1, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd_ptr >= obs_data.size()) begin errors++; $display("FAIL after_rst_data: got none want %h", e); end
      else begin
        if (obs_data[rd_ptr] !== e) begin errors++; $display("FAIL after_rst_data: got %h want %h", obs_data[rd_ptr], e); end
        rd_ptr++;
      end
    end
    last_good = 8'h42;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int v0, p0, f0;
    v0 = n_valid; p0 = n_perr; f0 = n_ferr;
    send_frame(8'h17, 1'b1, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    checks++; if (n_perr - p0 != 1) begin errors++; $display("FAIL parity_err: got %0d want 1", n_perr - p0); end
    checks++; if (n_valid - v0 != 0) begin errors++; $display("FAIL parity_valid: got %0d want 0", n_valid - v0); end
    checks++; if (n_ferr - f0 != 0) begin errors++; $display("FAIL parity_ferr: got %0d want 0", n_ferr - f0); end
    checks++; if (data !== last_good) begin errors++; $display("FAIL parity_data: got %h want %h", data, last_good); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_glitch();
    test_framing_break();
    test_back_to_back();
    test_mid_reset();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    checks++; if (n_overlap != 0) begin errors++; $display("FAIL strobe_overlap: got %0d want 0", n_overlap); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
